// File: rtl/palette_arbiter.sv
// Round-robin arbiter sharing one combinational palette lookup port among NREQ sprite requesters.
// Define PALETTE_ARB_STATS_EN to include the saturating accepted-lookup counter on lookup_count.
module palette_arbiter #(
  parameter int          NREQ    = 4,
  parameter logic [11:0] KEY_RGB = 12'hF0D
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [NREQ-1:0]     req,
  input  logic [4*NREQ-1:0]   index_in,
  input  logic                hold,
  output logic [NREQ-1:0]     grant,
  output logic [3:0]          pal_index,
  input  logic [11:0]         pal_rgb,
  output logic                rsp_valid,
  output logic [2:0]          rsp_id,
  output logic [3:0]          red,
  output logic [3:0]          green,
  output logic [3:0]          blue,
  output logic                rsp_transparent,
  output logic [15:0]         lookup_count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   rrPtr_q, rrPtr_d;
  logic [IW-1:0]   winner;
  logic [IW:0]     candSum;
  logic            found;
  logic            accept;
  logic [3:0]      winIndex;

  logic [NREQ-1:0] grant_q, grant_d;
  logic [3:0]      palIndex_q, palIndex_d;
  logic            pendValid_q, pendValid_d;
  logic [IW-1:0]   pendId_q, pendId_d;
  logic            rspValid_q, rspValid_d;
  logic [IW-1:0]   rspId_q, rspId_d;
  logic [11:0]     rgb_q, rgb_d;
  logic            transp_q, transp_d;

  // Scan requesters starting at the round-robin pointer; first one found wins.
  always_comb begin
    found   = 1'b0;
    winner  = rrPtr_q;
    candSum = '0;
    for (int k = 0; k < NREQ; k++) begin
      candSum = {1'b0, rrPtr_q} + (IW+1)'(k);
      if (candSum >= (IW+1)'(NREQ)) candSum = candSum - (IW+1)'(NREQ);
      if (!found && req[candSum[IW-1:0]]) begin
        found  = 1'b1;
        winner = candSum[IW-1:0];
      end
    end
  end

  assign accept = found & ~hold;

  always_comb begin
    winIndex = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == winner) winIndex = index_in[4*i +: 4];
    end
  end

  // The lookup accepted at one edge is captured from the palette at the next edge.
  always_comb begin
    grant_d     = '0;
    palIndex_d  = palIndex_q;
    rrPtr_d     = rrPtr_q;
    pendValid_d = accept;
    pendId_d    = pendId_q;
    if (accept) begin
      grant_d[winner] = 1'b1;
      palIndex_d      = winIndex;
      pendId_d        = winner;
      rrPtr_d         = (winner == IW'(NREQ-1)) ? '0 : winner + IW'(1);
    end

    rspValid_d = pendValid_q;
    rspId_d    = rspId_q;
    rgb_d      = rgb_q;
    transp_d   = 1'b0;
    if (pendValid_q) begin
      rspId_d  = pendId_q;
      rgb_d    = pal_rgb;
      transp_d = (pal_rgb == KEY_RGB);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rrPtr_q     <= '0;
      grant_q     <= '0;
      palIndex_q  <= '0;
      pendValid_q <= 1'b0;
      pendId_q    <= '0;
      rspValid_q  <= 1'b0;
      rspId_q     <= '0;
      rgb_q       <= '0;
      transp_q    <= 1'b0;
    end else begin
      rrPtr_q     <= rrPtr_d;
      grant_q     <= grant_d;
      palIndex_q  <= palIndex_d;
      pendValid_q <= pendValid_d;
      pendId_q    <= pendId_d;
      rspValid_q  <= rspValid_d;
      rspId_q     <= rspId_d;
      rgb_q       <= rgb_d;
      transp_q    <= transp_d;
    end
  end

  assign grant           = grant_q;
  assign pal_index       = palIndex_q;
  assign rsp_valid       = rspValid_q;
  assign rsp_id          = 3'(rspId_q);
  assign red             = rgb_q[11:8];
  assign green           = rgb_q[7:4];
  assign blue            = rgb_q[3:0];
  assign rsp_transparent = transp_q;

`ifdef PALETTE_ARB_STATS_EN
  logic [15:0] count_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
    end else if (accept && count_q != 16'hFFFF) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign lookup_count = count_q;
`else
  assign lookup_count = '0;
`endif

endmodule

// File: tb/tb_palette_arbiter.sv
// Self-checking bench for palette_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based model of the arbitration and lookup rules.
module tb_palette_arbiter;

  localparam int          NREQ = 4;
  localparam logic [11:0] KEY  = 12'hF0D;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              hold;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] index_in;
  logic [NREQ-1:0]   grant;
  logic [3:0]        pal_index;
  logic [11:0]       pal_rgb;
  logic              rsp_valid;
  logic [2:0]        rsp_id;
  logic [3:0]        red, green, blue;
  logic              rsp_transparent;
  logic [15:0]       lookup_count;

  logic [11:0] palMem [16];

  palette_arbiter #(.NREQ(NREQ), .KEY_RGB(KEY)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .index_in(index_in), .hold(hold),
    .grant(grant), .pal_index(pal_index), .pal_rgb(pal_rgb),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .red(red), .green(green), .blue(blue),
    .rsp_transparent(rsp_transparent), .lookup_count(lookup_count)
  );

  // Combinational palette seen by the DUT
  assign pal_rgb = palMem[pal_index];

  always #5 Clk = ~Clk;

  typedef struct {
    int id;
    int idx;
    int due;
  } lookup_t;

  lookup_t inflight[$];

  int              cycleNo = 0;
  int              mPtr    = 0;
  logic [NREQ-1:0] expGrant;
  logic [3:0]      expPalIdx;
  logic            expValid;
  logic [2:0]      expId;
  logic [11:0]     expRgb;
  logic            expTransp;
  logic [15:0]     expCount;

  int tests = 0;
  int fails = 0;

  // Drives one cycle of inputs, advances the model across the edge, then waits 1 time unit.
  task automatic applyStimulus(input logic rst, input logic h, input logic [NREQ-1:0] r,
                               input logic [4*NREQ-1:0] idx);
    lookup_t l;
    int w;
    Reset = rst; hold = h; req = r; index_in = idx;
    @(posedge Clk);
    cycleNo++;
    if (rst) begin
      inflight.delete();
      mPtr = 0; expGrant = '0; expPalIdx = '0; expValid = 1'b0; expId = '0;
      expRgb = '0; expTransp = 1'b0; expCount = '0;
    end else begin
      expValid = 1'b0; expTransp = 1'b0; expGrant = '0;
      if (inflight.size() > 0 && inflight[0].due == cycleNo) begin
        l = inflight.pop_front();
        expValid  = 1'b1;
        expId     = 3'(l.id);
        expRgb    = palMem[l.idx];
        expTransp = (expRgb == KEY);
      end
      if (!h && r != '0) begin
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && r[(mPtr + k) % NREQ]) w = (mPtr + k) % NREQ;
        expGrant  = NREQ'(1) << w;
        expPalIdx = idx[4*w +: 4];
        mPtr      = (w + 1) % NREQ;
        l.id = w; l.idx = int'(idx[4*w +: 4]); l.due = cycleNo + 1;
        inflight.push_back(l);
`ifdef PALETTE_ARB_STATS_EN
        if (expCount != 16'hFFFF) expCount = expCount + 16'd1;
`endif
      end
    end
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b1, '1, 16'hFFFF);
    applyStimulus(1'b1, 1'b0, '1, 16'h1234);
    tests++; if (grant !== 4'b0000) begin fails++; $display("[TB] FAIL reset_grant got %b want 0000", grant); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    tests++; if (pal_index !== 4'd0) begin fails++; $display("[TB] FAIL reset_pal_index got %h want 0", pal_index); end
    tests++; if (rsp_id !== 3'd0) begin fails++; $display("[TB] FAIL reset_rsp_id got %0d want 0", rsp_id); end
    tests++; if ({red, green, blue} !== 12'h000) begin fails++; $display("[TB] FAIL reset_rgb got %h want 000", {red, green, blue}); end
    tests++; if (rsp_transparent !== 1'b0) begin fails++; $display("[TB] FAIL reset_transparent got %b want 0", rsp_transparent); end
    tests++; if (lookup_count !== 16'd0) begin fails++; $display("[TB] FAIL reset_count got %h want 0", lookup_count); end
  endtask

  task automatic test_round_robin();
    logic [15:0] ix;
    applyStimulus(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++) begin
      ix = 16'($urandom);
      applyStimulus(1'b0, 1'b0, 4'b1111, ix);
      tests++; if (grant !== (4'b0001 << (i % 4))) begin fails++; $display("[TB] FAIL rr_grant cycle %0d got %b want %b", i, grant, 4'b0001 << (i % 4)); end
      tests++; if (pal_index !== ix[4*(i%4) +: 4]) begin fails++; $display("[TB] FAIL rr_pal_index cycle %0d got %h want %h", i, pal_index, ix[4*(i%4) +: 4]); end
      if (i > 0) begin
        tests++; if (rsp_valid !== 1'b1 || rsp_id !== 3'((i - 1) % 4)) begin fails++; $display("[TB] FAIL rr_rsp_id cycle %0d got v=%b id=%0d want v=1 id=%0d", i, rsp_valid, rsp_id, (i - 1) % 4); end
      end
    end
  endtask

  task automatic test_lookup(input int id, input logic [3:0] idx, input logic [11:0] colour,
                             input logic transp);
    logic [15:0] ix;
    palMem[idx] = colour;
    ix = 16'($urandom);
    ix[4*id +: 4] = idx;
    applyStimulus(1'b0, 1'b0, '0, ix);
    applyStimulus(1'b0, 1'b0, NREQ'(1) << id, ix);
    tests++; if (grant !== (NREQ'(1) << id) || rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL lookup%0d_grant got g=%b v=%b want g=%b v=0", id, grant, rsp_valid, NREQ'(1) << id); end
    applyStimulus(1'b0, 1'b0, '0, ix);
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 3'(id)) begin fails++; $display("[TB] FAIL lookup%0d_rsp got v=%b id=%0d want v=1 id=%0d", id, rsp_valid, rsp_id, id); end
    tests++; if ({red, green, blue} !== colour) begin fails++; $display("[TB] FAIL lookup%0d_rgb got %h want %h", id, {red, green, blue}, colour); end
    tests++; if (rsp_transparent !== transp) begin fails++; $display("[TB] FAIL lookup%0d_transparent got %b want %b", id, rsp_transparent, transp); end
    applyStimulus(1'b0, 1'b0, '0, ix);
    tests++; if (rsp_valid !== 1'b0 || rsp_transparent !== 1'b0 || {red, green, blue} !== colour) begin fails++; $display("[TB] FAIL lookup%0d_after got v=%b t=%b rgb=%h want v=0 t=0 rgb=%h", id, rsp_valid, rsp_transparent, {red, green, blue}, colour); end
  endtask

  task automatic test_hold_drain();
    applyStimulus(1'b1, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0, 4'b0011, 16'h0075);
    tests++; if (grant !== 4'b0001) begin fails++; $display("[TB] FAIL hold_first_grant got %b want 0001", grant); end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 4'b0011, 16'h0075);
      tests++; if (grant !== 4'b0000) begin fails++; $display("[TB] FAIL hold_grant cycle %0d got %b want 0000", i, grant); end
      tests++; if (rsp_valid !== (i == 0)) begin fails++; $display("[TB] FAIL hold_drain cycle %0d got %b want %b", i, rsp_valid, i == 0); end
      tests++; if (pal_index !== 4'h5) begin fails++; $display("[TB] FAIL hold_pal_index cycle %0d got %h want 5", i, pal_index); end
    end
    applyStimulus(1'b0, 1'b0, 4'b0011, 16'h0075);
    tests++; if (grant !== 4'b0010 || pal_index !== 4'h7) begin fails++; $display("[TB] FAIL hold_resume got g=%b idx=%h want g=0010 idx=7", grant, pal_index); end
  endtask

  task automatic test_reset_midflight();
    applyStimulus(1'b1, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0, 4'b1111, 16'hABCD);
    applyStimulus(1'b1, 1'b0, 4'b1111, 16'hABCD);
    tests++; if (rsp_valid !== 1'b0 || grant !== 4'b0000 || pal_index !== 4'd0) begin fails++; $display("[TB] FAIL midreset_outputs got v=%b g=%b idx=%h want 0/0000/0", rsp_valid, grant, pal_index); end
    applyStimulus(1'b0, 1'b0, '0, 16'hABCD);
    tests++; if (rsp_valid !== 1'b0 || {red, green, blue} !== 12'h000 || rsp_id !== 3'd0) begin fails++; $display("[TB] FAIL midreset_discard got v=%b rgb=%h id=%0d want 0/000/0", rsp_valid, {red, green, blue}, rsp_id); end
    applyStimulus(1'b0, 1'b0, 4'b1111, 16'hABCD);
    tests++; if (grant !== 4'b0001) begin fails++; $display("[TB] FAIL midreset_regrant got %b want 0001", grant); end
  endtask

  task automatic test_random();
    for (int a = 0; a < 16; a++) palMem[a] = 12'($urandom);
    palMem[3] = KEY;
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, NREQ'($urandom), 16'($urandom));
      tests++; if (grant !== expGrant) begin fails++; $display("[TB] FAIL rand_grant cycle %0d got %b want %b", i, grant, expGrant); end
      tests++; if (pal_index !== expPalIdx) begin fails++; $display("[TB] FAIL rand_pal_index cycle %0d got %h want %h", i, pal_index, expPalIdx); end
      tests++; if (rsp_valid !== expValid) begin fails++; $display("[TB] FAIL rand_rsp_valid cycle %0d got %b want %b", i, rsp_valid, expValid); end
      tests++; if (rsp_id !== expId) begin fails++; $display("[TB] FAIL rand_rsp_id cycle %0d got %0d want %0d", i, rsp_id, expId); end
      tests++; if ({red, green, blue} !== expRgb) begin fails++; $display("[TB] FAIL rand_rgb cycle %0d got %h want %h", i, {red, green, blue}, expRgb); end
      tests++; if (rsp_transparent !== expTransp) begin fails++; $display("[TB] FAIL rand_transparent cycle %0d got %b want %b", i, rsp_transparent, expTransp); end
      tests++; if (lookup_count !== expCount) begin fails++; $display("[TB] FAIL rand_count cycle %0d got %h want %h", i, lookup_count, expCount); end
    end
  endtask

  task automatic test_stats();
    applyStimulus(1'b1, 1'b0, '0, '0);
`ifdef PALETTE_ARB_STATS_EN
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 4'b1111, 16'($urandom));
    tests++; if (lookup_count !== 16'd5) begin fails++; $display("[TB] FAIL stats_small got %h want 0005", lookup_count); end
    applyStimulus(1'b0, 1'b1, 4'b1111, '0);
    tests++; if (lookup_count !== 16'd5) begin fails++; $display("[TB] FAIL stats_hold got %h want 0005", lookup_count); end
    for (int i = 5; i < 70000; i++) applyStimulus(1'b0, 1'b0, 4'b1111, 16'($urandom));
    tests++; if (lookup_count !== 16'hFFFF) begin fails++; $display("[TB] FAIL stats_saturate got %h want FFFF", lookup_count); end
`else
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 4'b1111, 16'($urandom));
      tests++; if (lookup_count !== 16'd0) begin fails++; $display("[TB] FAIL stats_disabled cycle %0d got %h want 0000", i, lookup_count); end
    end
`endif
  endtask

  initial begin
    for (int a = 0; a < 16; a++) palMem[a] = 12'h000;
    Reset = 1'b1; hold = 1'b0; req = '0; index_in = '0;
    test_reset();
    test_round_robin();
    test_lookup(2, 4'd1, 12'hFFF, 1'b0);
    test_lookup(0, 4'd0, 12'hF0D, 1'b1);
    test_hold_drain();
    test_reset_midflight();
    test_random();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/palette_arbiter.md
PALETTE_ARBITER -- requirements
Module: palette_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of sprite requesters sharing one palette lookup port (2..8).
REQ-002 SHALL have parameter KEY_RGB, default 12'hF0D: transparency key colour {R,G,B}.
REQ-003 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  NREQ  per-requester lookup request, held high until granted.
REQ-006 SHALL have port index_in  input  4*NREQ  requester i's palette index in bits [4i+3:4i].
REQ-007 SHALL have port hold  input  1  when high, no new grants are issued (blanking/stall).
REQ-008 SHALL have port grant  output  NREQ  one-hot, one-cycle pulse marking the accepted request.
REQ-009 SHALL have port pal_index  output  4  registered index driven to the combinational palette.
REQ-010 SHALL have port pal_rgb  input  12  palette colour {R,G,B} for pal_index, same cycle.
REQ-011 SHALL have port rsp_valid  output  1  response strobe, one cycle per accepted lookup.
REQ-012 SHALL have port rsp_id  output  3  requester number owning the response.
REQ-013 SHALL have ports red, green, blue  output  4 each  registered looked-up colour.
REQ-014 SHALL have port rsp_transparent  output  1  high when the response colour equals KEY_RGB.
REQ-015 SHALL have port lookup_count  output  16  accepted-lookup statistic (see Configuration).

Function
REQ-016 SHALL, at each rising edge with hold=0 and any req bit high, accept exactly one requester, chosen round-robin starting at rr_ptr.
REQ-017 SHALL, on accepting requester i, set grant[i]=1 and pal_index=index_in[i] for the following cycle, and set rr_ptr=(i+1) mod NREQ.
REQ-018 SHALL hold grant at all-zero and leave rr_ptr and pal_index unchanged in any cycle where no request is accepted.
REQ-019 SHALL treat a req bit still high in its own grant cycle as a new request competing under the rotated pointer.
REQ-020 SHALL, one edge after acceptance, register pal_rgb into {red,green,blue}, the accepted id into rsp_id, and pulse rsp_valid: total latency 2 edges request-to-response.
REQ-021 SHALL sustain one accepted lookup per cycle (full throughput) with back-to-back responses.
REQ-022 SHALL set rsp_transparent = ({red,green,blue} == KEY_RGB) in the rsp_valid cycle, and 0 when rsp_valid=0.
REQ-023 SHALL, when hold rises, complete any lookup already accepted (drain) while accepting none new.
REQ-024 SHALL hold red, green, blue, rsp_id at their last values when rsp_valid=0.
REQ-025 SHALL guarantee any requester holding req high is granted within NREQ accepting cycles (no starvation).

Reset
REQ-026 SHALL, on Reset high at an edge, set grant=0, rsp_valid=0, rsp_transparent=0, pal_index=0, rsp_id=0, red=green=blue=0, rr_ptr=0, lookup_count=0.
REQ-027 SHALL discard any in-flight lookup when Reset is asserted mid-operation; no rsp_valid follows the reset edge.
REQ-028 SHALL give Reset priority over hold and req in the same cycle.

Configuration
REQ-029 SHALL use macro PALETTE_ARB_STATS_EN to include lookup statistics.
REQ-030 SHALL, with PALETTE_ARB_STATS_EN defined, increment lookup_count by 1 per accepted lookup, saturating at 16'hFFFF.
REQ-031 SHALL, without PALETTE_ARB_STATS_EN, drive lookup_count constantly 0 and implement no counter logic.

Verification
REQ-032 SHALL verify: NREQ=4, req=4'b1111 held 8 cycles, hold=0 -> grants 0,1,2,3,0,1,2,3 on consecutive cycles; rsp_id follows one cycle later.
REQ-033 SHALL verify: req[2] only, index_in[2]=4'd1, palette returns 12'hFFF -> rsp_valid 2 edges later, rsp_id=2, RGB=F/F/F, rsp_transparent=0.
REQ-034 SHALL verify: req[0], index=4'd0, palette 12'hF0D -> response RGB=F/0/D, rsp_transparent=1.
REQ-035 SHALL verify: hold=1 asserted the cycle after an acceptance with req=4'b0011 -> one pending response completes, no further grant until hold=0, then grant resumes at rr_ptr.
REQ-036 SHALL verify: Reset pulsed the cycle after an acceptance -> no rsp_valid, all outputs 0, next grant with req=4'b1111 goes to requester 0.
REQ-037 SHALL verify: with PALETTE_ARB_STATS_EN, 70000 back-to-back lookups -> lookup_count=16'hFFFF; without macro -> lookup_count=0 throughout.
